// File: rtl/fourbit_add_seq_if.sv
// Bus between the nibble-serial add/sub sequencer and its environment:
// the requester (start/operands/result) and the external 4-bit adder.
interface fourbit_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // requester side
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // external 4-bit adder
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;

  // environment: requester plus the combinational adder
  modport master (
    output start, sub, cin, a, b, add_s, add_cout,
    input  busy, done, sum, cout, ovf, add_a, add_b, add_cin
  );

  // the sequencer
  modport slave (
    input  start, sub, cin, a, b, add_s, add_cout,
    output busy, done, sum, cout, ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/fourbit_add_seq.sv
// Nibble-serial W-bit add/subtract controller. Feeds the external 4-bit
// adder one nibble per clock, LSB first, ripples the carry through a
// register and assembles the result plus carry/overflow flags.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one nibble through the adder per clock, idx = current nibble
// DONE  | single cycle, done=1, result valid; start here relaunches
module fourbit_add_seq #(
  parameter int NIBBLES = 4
) (
  input logic              clk,
  input logic              rst,
  fourbit_add_seq_if.slave bus
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic [NIBBLES-1:0][3:0] a_reg;
  logic [NIBBLES-1:0][3:0] b_reg;
  logic [NIBBLES-1:0][3:0] sum_q;
  logic                    cout_q;
  logic                    ovf_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    last;

  assign last     = (idx == IW'(NIBBLES - 1));

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

  // Present the current nibble and carry to the adder; quiet outside RUN
  always_comb begin
    bus.add_a   = 4'h0;
    bus.add_b   = 4'h0;
    bus.add_cin = 1'b0;
    if (state == RUN) begin
      bus.add_a   = a_reg[idx];
      bus.add_b   = b_reg[idx];
      bus.add_cin = carry;
    end
  end

  // Sequencer FSM with operand capture, nibble result capture and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // subtract is a + ~b + 1, so invert b and force the carry in
            a_reg  <= bus.a;
            b_reg  <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            idx    <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx] <= bus.add_s;
          carry      <= bus.add_cout;
          if (last) begin
            cout_q <= bus.add_cout;
            // same-sign effective operands producing a different-sign result
            ovf_q  <= (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
                      (bus.add_s[3] != a_reg[NIBBLES-1][3]);
            idx    <= '0;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          idx    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fourbit_add_seq.sv
// Testbench for fourbit_add_seq: models the external 4-bit adder and checks
// results, flags, latency and handshake against an arithmetic reference.
module tb_fourbit_add_seq;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fourbit_add_seq_if #(.NIBBLES(NIB)) bus ();

  fourbit_add_seq #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // the external 4-bit full adder
  assign {bus.add_cout, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

  int checks = 0;
  int errors = 0;

  logic [3:0] seq_a[$];
  logic [3:0] seq_b[$];
  logic       seq_cin[$];
  int         busy_cnt;

  // busy and done must never be high together
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((bus.busy & bus.done) !== 1'b0) begin
        errors++;
        $display("FAIL busy_done_excl: busy=%b done=%b required not both 1", bus.busy, bus.done);
      end
    end
  end

  // Reference: plain W-bit unsigned and signed arithmetic
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic ci, output logic [W-1:0] es, output logic eco,
                       output logic eov);
    logic [W:0] u;
    int signed  tr;
    if (!s) begin
      u   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      tr  = int'($signed(a)) + int'($signed(b)) + int'(ci);
      eco = u[W];
    end else begin
      u   = {1'b0, a} - {1'b0, b};
      tr  = int'($signed(a)) - int'($signed(b));
      eco = (a >= b);
    end
    es  = u[W-1:0];
    eov = (tr > 32767) || (tr < -32768);
  endtask

  // Called at a negedge: present an operation with start=1
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
    bus.cin   = ci;
    bus.start = 1'b1;
  endtask

  // Counts edges from the start negedge to done, logging adder drive in RUN
  task automatic wait_done(input string name, input bit hold_start, output int edges);
    edges    = 0;
    busy_cnt = 0;
    seq_a.delete();
    seq_b.delete();
    seq_cin.delete();
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1 && !hold_start) bus.start = 1'b0;
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        seq_a.push_back(bus.add_a);
        seq_b.push_back(bus.add_b);
        seq_cin.push_back(bus.add_cin);
      end
    end while (bus.done !== 1'b1 && edges < 20);
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done after %0d edges", name, edges);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum, bus.add_a, bus.add_b, bus.add_cin} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b cout=%b ovf=%b sum=%h add_a=%h add_b=%h add_cin=%b required all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum, bus.add_a, bus.add_b, bus.add_cin);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6], tb_[6], tsum[6];
    logic         tsub[6], tcin[6], tco[6], tov[6];
    logic [W-1:0] es;
    logic         eco, eov;
    logic [15:0]  packed_a;
    logic [3:0]   packed_c;
    int           edges;
    ta   = '{16'h1234, 16'hFFFF, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
    tb_  = '{16'h1111, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
    tsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tcin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tsum = '{16'h2345, 16'h0000, 16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000};
    tco  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      model(ta[i], tb_[i], tsub[i], tcin[i], es, eco, eov);
      launch(ta[i], tb_[i], tsub[i], tcin[i]);
      wait_done("directed", 1'b0, edges);
      checks++;
      if ({bus.sum, bus.cout, bus.ovf} !== {tsum[i], tco[i], tov[i]} ||
          {es, eco, eov} !== {tsum[i], tco[i], tov[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 i, bus.sum, bus.cout, bus.ovf, tsum[i], tco[i], tov[i]);
      end
      checks++;
      if (edges != NIB + 1 || busy_cnt != NIB) begin
        errors++;
        $display("FAIL directed_latency[%0d]: edges=%0d busy_cycles=%0d required %0d and %0d",
                 i, edges, busy_cnt, NIB + 1, NIB);
      end
      if (i == 0) begin
        packed_a = (seq_a.size() == 4) ? {seq_a[0], seq_a[1], seq_a[2], seq_a[3]} : 16'hxxxx;
        checks++;
        if (packed_a !== 16'h4321) begin
          errors++;
          $display("FAIL add_a_sequence: got %h required 4321", packed_a);
        end
      end
      if (i == 1) begin
        packed_c = (seq_cin.size() == 4) ? {seq_cin[0], seq_cin[1], seq_cin[2], seq_cin[3]} : 4'bxxxx;
        checks++;
        if (packed_c !== 4'b0111) begin
          errors++;
          $display("FAIL add_cin_sequence: got %b required 0111", packed_c);
        end
      end
      // done is a single pulse and the result holds through IDLE
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== tsum[i]) begin
        errors++;
        $display("FAIL directed_hold[%0d]: done=%b busy=%b sum=%h required done=0 busy=0 sum=%h",
                 i, bus.done, bus.busy, bus.sum, tsum[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    launch(16'h0F0F, 16'h7070, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    edges = 3;
    while (bus.done !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (bus.done !== 1'b1 || edges != NIB + 1 || {bus.sum, bus.cout, bus.ovf} !== {16'h3333, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_start: done=%b edges=%0d sum=%h cout=%b ovf=%b required done=1 edges=%0d sum=3333 cout=0 ovf=0",
               bus.done, edges, bus.sum, bus.cout, bus.ovf, NIB + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [W-1:0] es;
    logic eco, eov;
    launch(16'h0100, 16'h0200, 1'b0, 1'b0);
    wait_done("b2b_first", 1'b1, edges);
    checks++;
    if (edges != NIB + 1 || bus.sum !== 16'h0300) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d sum=%h required edges=%0d sum=0300", edges, bus.sum, NIB + 1);
    end
    // start still high in DONE: second op must launch with no IDLE gap
    launch(16'h9000, 16'h1234, 1'b1, 1'b0);
    model(16'h9000, 16'h1234, 1'b1, 1'b0, es, eco, eov);
    wait_done("b2b_second", 1'b0, edges);
    checks++;
    if (edges != NIB + 1 || busy_cnt != NIB || {bus.sum, bus.cout, bus.ovf} !== {es, eco, eov}) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d busy_cycles=%0d sum=%h cout=%b ovf=%b required edges=%0d sum=%h cout=%b ovf=%b",
               edges, busy_cnt, bus.sum, bus.cout, bus.ovf, NIB + 1, es, eco, eov);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int edges;
    launch(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum, bus.add_a, bus.add_b, bus.add_cin} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b cout=%b ovf=%b sum=%h add_a=%h add_b=%h add_cin=%b required all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum, bus.add_a, bus.add_b, bus.add_cin);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_done("after_reset", 1'b0, edges);
    checks++;
    if ({bus.sum, bus.cout, bus.ovf} !== {16'h0100, 1'b0, 1'b0} || edges != NIB + 1) begin
      errors++;
      $display("FAIL after_reset: sum=%h cout=%b ovf=%b edges=%0d required sum=0100 cout=0 ovf=0 edges=%0d",
               bus.sum, bus.cout, bus.ovf, edges, NIB + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, es, beff;
    logic         s, ci, eco, eov;
    logic [W-1:0] got_a, got_b;
    int           edges;
    for (int n = 0; n < 40; n++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      s  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      if (n % 8 == 0) a = 16'h8000;
      if (n % 8 == 1) b = 16'h7FFF;
      model(a, b, s, ci, es, eco, eov);
      beff = s ? ~b : b;
      launch(a, b, s, ci);
      wait_done("random", 1'b0, edges);
      checks++;
      if ({bus.sum, bus.cout, bus.ovf} !== {es, eco, eov} || edges != NIB + 1) begin
        errors++;
        $display("FAIL random[%0d]: a=%h b=%h sub=%b cin=%b sum=%h cout=%b ovf=%b edges=%0d required sum=%h cout=%b ovf=%b edges=%0d",
                 n, a, b, s, ci, bus.sum, bus.cout, bus.ovf, edges, es, eco, eov, NIB + 1);
      end
      got_a = (seq_a.size() == 4) ? {seq_a[3], seq_a[2], seq_a[1], seq_a[0]} : 16'hxxxx;
      got_b = (seq_b.size() == 4) ? {seq_b[3], seq_b[2], seq_b[1], seq_b[0]} : 16'hxxxx;
      checks++;
      if (got_a !== a || got_b !== beff) begin
        errors++;
        $display("FAIL random_drive[%0d]: add_a nibbles=%h add_b nibbles=%h required %h and %h",
                 n, got_a, got_b, a, beff);
      end
      if (n % 3 == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
